picomem_bus_timeout: RTL and testbench
======================================

// Module: picomem_bus_timeout
// PURPOSE
//   Bus watchdog between the picorv32 native memory master and the PicoMem 1:4 address mux.
//   Normally passes every transaction straight through with zero added latency.
//   If the selected slave does not assert ready within TIMEOUT_CYCLES, the block does three things:
//   - ends the transfer itself, returning ERR_RDATA;
//   - withdraws valid from the slave;
//   - records the failing address, so an unmapped or hung slave cannot stall the CPU.
// PARAMETERS
//   TIMEOUT_CYCLES  256           cycles of m_valid without s_ready before abort; 0 = watchdog off (pure pass-through)
//   ERR_RDATA       32'hDEADBEEF  read data returned to the master on an aborted transfer
// PORTS
//   clk          in   1   system clock, all logic on rising edge
//   reset        in   1   synchronous, active-high reset
//   m_valid      in   1   master request valid
//   m_addr       in   32  master address
//   m_wdata      in   32  master write data
//   m_wstrb      in   4   master byte strobes (0 = read)
//   m_ready      out  1   transfer complete to master
//   m_rdata      out  32  read data to master
//   s_valid      out  1   request valid to mux/slaves
//   s_addr       out  32  = m_addr
//   s_wdata      out  32  = m_wdata
//   s_wstrb      out  4   = m_wstrb
//   s_ready      in   1   slave-side ready from mux
//   s_rdata      in   32  slave-side read data from mux
//   err_clr      in   1   one-cycle pulse; clears err_flag and err_count
//   err_flag     out  1   sticky: at least one abort since reset/clear (usable as IRQ)
//   err_addr     out  32  address of most recent aborted transfer
//   err_write    out  1   1 if most recent aborted transfer was a write (|m_wstrb)
//   err_count    out  8   aborts since reset/clear, saturates at 255
// BEHAVIOUR
//   - Clock and reset: single clock clk; reset is synchronous and active-high.
//   - Reset values: state=PASS, cnt=0, err_flag=0, err_addr=0, err_write=0, err_count=0.
//     While reset=1, s_valid=0 and m_ready=0 (combinational override).
//   - Counter: cnt is $clog2(TIMEOUT_CYCLES+1) bits wide and never wraps.
//   - FSM state PASS:
//     - s_valid=m_valid, m_ready=s_ready, m_rdata=s_rdata; all combinational, 0 extra latency.
//     - cnt <= (m_valid && !s_ready) ? cnt+1 : 0.
//     - If m_valid && !s_ready && cnt==TIMEOUT_CYCLES-1 (and TIMEOUT_CYCLES!=0) -> ABORT.
//     - Hence a slave ready on cycle k after valid rises (k=0..TIMEOUT_CYCLES-1) completes normally.
//   - FSM state ABORT (exactly 1 cycle):
//     - s_valid=0, m_ready=1, m_rdata=ERR_RDATA.
//     - Latch err_addr<=m_addr and err_write<=|m_wstrb; err_flag<=1; err_count<=sat(err_count+1).
//     - -> GAP.
//     - Abort handshake lands TIMEOUT_CYCLES cycles after m_valid rises.
//   - FSM state GAP (exactly 1 cycle):
//     - s_valid=0, m_ready=0, cnt<=0.
//     - Guarantees the slaves see valid low; -> PASS.
//   - Late s_ready in ABORT or GAP: ignored and never forwarded.
//     Writes that already reached a slave are not undone.
//   - s_ready in the same cycle cnt==TIMEOUT_CYCLES-1: normal completion, no abort.
//   - m_valid dropping before ready (protocol violation): cnt returns to 0, no abort.
//   - err_clr concurrent with ABORT: abort wins, err_flag=1, err_count=1.
//   - Reset mid-transfer/abort: returns to PASS next edge, err_* cleared.
//     s_valid and m_ready are forced low for the whole reset cycle.
//   - TIMEOUT_CYCLES=0: FSM held in PASS; err_* stay at reset values.
// TESTING
//   1 TIMEOUT=8, read with s_ready on cycle 3, s_rdata=0x12345678 -> m_ready cycle 3, m_rdata=0x12345678, err_flag=0.
//   2 TIMEOUT=8, read 0x5000_0000, s_ready never -> m_ready=1 on cycle 8 with 0xDEADBEEF.
//     Also: s_valid low on cycles 8-9, err_addr=0x5000_0000, err_write=0, err_count=1.
//   3 TIMEOUT=8, write wstrb=4'hF with s_ready on cycle 7 -> normal completion, no abort.
//     Same write with ready on cycle 8 -> abort, err_write=1.
//   4 300 back-to-back timeouts -> err_count=255; err_clr pulse -> err_flag=0, err_count=0.
//     err_clr coincident with ABORT -> err_count=1, err_flag=1.
//   5 Assert reset during WAIT (cnt=5) -> next cycle s_valid=0, m_ready=0, cnt=0, err_*=0.
//     A fresh transfer then times out at a full 8 cycles.
//   6 TIMEOUT=0, hung slave for 1000 cycles -> m_ready stays 0, s_valid=m_valid, err_flag=0.

Source files
------------

// File: rtl/picomem_bus_timeout.sv
// Bus watchdog between picorv32 and the PicoMem mux: zero-latency pass-through, aborts a stalled transfer.
// Backpressure passes straight through; after TIMEOUT_CYCLES stalled cycles the master gets ERR_RDATA.
module picomem_bus_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_valid,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    input  logic [3:0]  m_wstrb,
    output logic        m_ready,
    output logic [31:0] m_rdata,
    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    input  logic        err_clr,
    output logic        err_flag,
    output logic [31:0] err_addr,
    output logic        err_write,
    output logic [7:0]  err_count
);

    localparam int unsigned   CW       = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam bit            WD_EN    = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {ST_PASS, ST_ABORT, ST_GAP} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_flag_q, err_flag_d;
    logic [31:0]   err_addr_q, err_addr_d;
    logic          err_write_q, err_write_d;
    logic [7:0]    err_count_q, err_count_d;
    logic [7:0]    count_base;
    logic          stall;

    assign stall = m_valid && !s_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_PASS;
            cnt_q       <= '0;
            err_flag_q  <= 1'b0;
            err_addr_q  <= '0;
            err_write_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_flag_q  <= err_flag_d;
            err_addr_q  <= err_addr_d;
            err_write_q <= err_write_d;
            err_count_q <= err_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_flag_d  = err_flag_q;
        err_addr_d  = err_addr_q;
        err_write_d = err_write_q;
        err_count_d = err_count_q;
        count_base  = err_clr ? 8'd0 : err_count_q;
        if (err_clr) begin
            err_flag_d  = 1'b0;
            err_count_d = 8'd0;
        end
        case (state_q)
            ST_PASS: begin
                cnt_d = (WD_EN && stall) ? cnt_q + 1'b1 : '0;
                if (WD_EN && stall && cnt_q == CNT_LAST) begin
                    state_d = ST_ABORT;
                end
            end
            ST_ABORT: begin
                // A coincident clear loses to the abort: the count restarts at one.
                err_flag_d  = 1'b1;
                err_addr_d  = m_addr;
                err_write_d = |m_wstrb;
                err_count_d = (count_base == 8'hFF) ? 8'hFF : count_base + 8'd1;
                state_d     = ST_GAP;
            end
            ST_GAP: begin
                cnt_d   = '0;
                state_d = ST_PASS;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_PASS;
            end
        endcase
    end

    always_comb begin
        s_valid = 1'b0;
        m_ready = 1'b0;
        m_rdata = s_rdata;
        case (state_q)
            ST_PASS: begin
                s_valid = m_valid;
                m_ready = s_ready;
            end
            ST_ABORT: begin
                m_ready = 1'b1;
                m_rdata = ERR_RDATA;
            end
            default: begin
                s_valid = 1'b0;
                m_ready = 1'b0;
            end
        endcase
        if (reset) begin
            s_valid = 1'b0;
            m_ready = 1'b0;
        end
    end

    assign s_addr    = m_addr;
    assign s_wdata   = m_wdata;
    assign s_wstrb   = m_wstrb;
    assign err_flag  = err_flag_q;
    assign err_addr  = err_addr_q;
    assign err_write = err_write_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_picomem_bus_timeout.sv
// Directed bench: a TIMEOUT=8 watchdog driven from a transaction table plus corner sequences, and a TIMEOUT=0 pass-through.
module tb_picomem_bus_timeout;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic        m_valid, m_ready, s_valid, s_ready, err_clr, err_flag, err_write;
    logic [31:0] m_addr, m_wdata, m_rdata, s_addr, s_wdata, s_rdata, err_addr;
    logic [3:0]  m_wstrb, s_wstrb;
    logic [7:0]  err_count;

    logic        z_m_valid, z_m_ready, z_s_valid, z_s_ready, z_err_clr, z_err_flag, z_err_write;
    logic [31:0] z_m_addr, z_m_wdata, z_m_rdata, z_s_addr, z_s_wdata, z_s_rdata, z_err_addr;
    logic [3:0]  z_m_wstrb, z_s_wstrb;
    logic [7:0]  z_err_count;

    picomem_bus_timeout #(.TIMEOUT_CYCLES(8), .ERR_RDATA(32'hDEADBEEF)) dut (
        .clk(clk), .reset(reset),
        .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_ready(m_ready), .m_rdata(m_rdata),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .err_clr(err_clr), .err_flag(err_flag), .err_addr(err_addr),
        .err_write(err_write), .err_count(err_count)
    );

    picomem_bus_timeout #(.TIMEOUT_CYCLES(0), .ERR_RDATA(32'hDEADBEEF)) dut_off (
        .clk(clk), .reset(reset),
        .m_valid(z_m_valid), .m_addr(z_m_addr), .m_wdata(z_m_wdata), .m_wstrb(z_m_wstrb),
        .m_ready(z_m_ready), .m_rdata(z_m_rdata),
        .s_valid(z_s_valid), .s_addr(z_s_addr), .s_wdata(z_s_wdata), .s_wstrb(z_s_wstrb),
        .s_ready(z_s_ready), .s_rdata(z_s_rdata),
        .err_clr(z_err_clr), .err_flag(z_err_flag), .err_addr(z_err_addr),
        .err_write(z_err_write), .err_count(z_err_count)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          rdy_cyc;   // cycle the slave raises ready, -1 = never
        logic [31:0] srdata;
        int          exp_cyc;
        logic [31:0] exp_rdata;
        logic        exp_flag;
        logic        exp_write;
        logic [7:0]  exp_count;
        logic [31:0] exp_eaddr;
    } vec_t;

    vec_t vecs[7];
    int   nvec = 0;
    int   nbad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Entered #1 after a rising edge; returns #1 after the edge that follows the handshake, with m_valid low.
    task automatic run_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                           input int rdy, input logic [31:0] rd,
                           output int cyc, output logic [31:0] got, output logic sv0);
        int k;
        k = 0; cyc = -1; got = '0; sv0 = 1'b0;
        m_valid = 1'b1; m_addr = a; m_wdata = wd; m_wstrb = ws; s_rdata = rd;
        s_ready = (rdy == 0);
        while (k < 400) begin
            @(negedge clk);
            if (k == 0) sv0 = s_valid && (s_addr == a) && (s_wdata == wd) && (s_wstrb == ws);
            if (m_ready) begin
                cyc = k;
                got = m_rdata;
                break;
            end
            @(posedge clk); #1;
            k++;
            s_ready = (k == rdy);
        end
        @(posedge clk); #1;
        m_valid = 1'b0; s_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench time limit");
    end

    initial begin
        int          cyc;
        logic [31:0] got;
        logic        sv0;
        int          bad_cnt;

        vecs[0] = '{32'h1000_0000, 32'h0,         4'h0, 3,  32'h1234_5678, 3, 32'h1234_5678, 1'b0, 1'b0, 8'd0, 32'h0};
        vecs[1] = '{32'h1000_0004, 32'h0,         4'h0, 0,  32'hA5A5_0001, 0, 32'hA5A5_0001, 1'b0, 1'b0, 8'd0, 32'h0};
        vecs[2] = '{32'h2000_0000, 32'h0000_CAFE, 4'hF, 7,  32'h0,         7, 32'h0,         1'b0, 1'b0, 8'd0, 32'h0};
        vecs[3] = '{32'h5000_0000, 32'h0,         4'h0, -1, 32'h7777_7777, 8, 32'hDEAD_BEEF, 1'b1, 1'b0, 8'd1, 32'h5000_0000};
        vecs[4] = '{32'h2000_0000, 32'h0000_CAFE, 4'hF, 8,  32'h1111_1111, 8, 32'hDEAD_BEEF, 1'b1, 1'b1, 8'd2, 32'h2000_0000};
        vecs[5] = '{32'h3000_0010, 32'h0000_00AB, 4'h1, 5,  32'h2222_2222, 5, 32'h2222_2222, 1'b1, 1'b1, 8'd2, 32'h2000_0000};
        vecs[6] = '{32'h4000_0000, 32'h0,         4'h0, 7,  32'h3333_3333, 7, 32'h3333_3333, 1'b1, 1'b1, 8'd2, 32'h2000_0000};

        // Reset with a live request on both instances: handshakes must be forced low.
        reset = 1'b1; err_clr = 1'b0; z_err_clr = 1'b0;
        m_valid = 1'b1; m_addr = 32'h0; m_wdata = 32'h0; m_wstrb = 4'h0; s_ready = 1'b1; s_rdata = 32'h0;
        z_m_valid = 1'b1; z_m_addr = 32'h0; z_m_wdata = 32'h0; z_m_wstrb = 4'h0; z_s_ready = 1'b1; z_s_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_s_valid", 32'(s_valid), 32'd0);
        chk("rst_m_ready", 32'(m_ready), 32'd0);
        chk("rst_off_s_valid", 32'(z_s_valid), 32'd0);
        chk("rst_off_m_ready", 32'(z_m_ready), 32'd0);
        chk("rst_err_flag", 32'(err_flag), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_err_addr", err_addr, 32'd0);
        chk("rst_err_write", 32'(err_write), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; m_valid = 1'b0; s_ready = 1'b0; z_m_valid = 1'b0; z_s_ready = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].rdy_cyc, vecs[i].srdata, cyc, got, sv0);
            @(negedge clk);
            chk($sformatf("v%0d_fwd", i), 32'(sv0), 32'd1);
            chk($sformatf("v%0d_ready_cycle", i), 32'(cyc), 32'(vecs[i].exp_cyc));
            chk($sformatf("v%0d_rdata", i), got, vecs[i].exp_rdata);
            chk($sformatf("v%0d_err_flag", i), 32'(err_flag), 32'(vecs[i].exp_flag));
            chk($sformatf("v%0d_err_write", i), 32'(err_write), 32'(vecs[i].exp_write));
            chk($sformatf("v%0d_err_count", i), 32'(err_count), 32'(vecs[i].exp_count));
            chk($sformatf("v%0d_err_addr", i), err_addr, vecs[i].exp_eaddr);
            @(posedge clk); #1;
        end

        // Abort followed by a GAP cycle with valid still high and a late ready.
        m_valid = 1'b1; m_addr = 32'h6000_0000; m_wstrb = 4'h0; s_ready = 1'b0; s_rdata = 32'h4444_4444;
        repeat (8) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("gap_abort_m_ready", 32'(m_ready), 32'd1);
        chk("gap_abort_rdata", m_rdata, 32'hDEAD_BEEF);
        chk("gap_abort_s_valid", 32'(s_valid), 32'd0);
        @(posedge clk); #1;
        s_ready = 1'b1;
        @(negedge clk);
        chk("gap_s_valid", 32'(s_valid), 32'd0);
        chk("gap_late_ready", 32'(m_ready), 32'd0);
        chk("gap_err_count", 32'(err_count), 32'd3);
        chk("gap_err_addr", err_addr, 32'h6000_0000);
        @(posedge clk); #1;
        m_valid = 1'b0; s_ready = 1'b0;
        @(posedge clk); #1;

        // Saturation, then clear coincident with an abort, then a plain clear.
        for (int i = 0; i < 300; i++) begin
            run_txn(32'h5000_0000 + 32'(i), 32'h0, 4'h0, -1, 32'h0, cyc, got, sv0);
        end
        @(negedge clk);
        chk("sat_err_count", 32'(err_count), 32'd255);
        chk("sat_err_flag", 32'(err_flag), 32'd1);
        @(posedge clk); #1;
        m_valid = 1'b1; m_addr = 32'h5100_0000; s_ready = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        err_clr = 1'b1;
        @(negedge clk);
        chk("clr_abort_m_ready", 32'(m_ready), 32'd1);
        @(posedge clk); #1;
        err_clr = 1'b0; m_valid = 1'b0;
        @(negedge clk);
        chk("clr_abort_err_count", 32'(err_count), 32'd1);
        chk("clr_abort_err_flag", 32'(err_flag), 32'd1);
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk);
        chk("clr_err_flag", 32'(err_flag), 32'd0);
        chk("clr_err_count", 32'(err_count), 32'd0);
        @(posedge clk); #1;

        // Reset while waiting with cnt=5, then a fresh full-length timeout.
        run_txn(32'h7000_0000, 32'h1, 4'h3, -1, 32'h0, cyc, got, sv0);
        @(posedge clk); #1;
        m_valid = 1'b1; m_addr = 32'h7100_0000; m_wstrb = 4'h0; s_ready = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_s_valid", 32'(s_valid), 32'd0);
        chk("mid_rst_m_ready", 32'(m_ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_err_flag", 32'(err_flag), 32'd0);
        chk("post_rst_err_count", 32'(err_count), 32'd0);
        chk("post_rst_err_addr", err_addr, 32'd0);
        chk("post_rst_err_write", 32'(err_write), 32'd0);
        chk("post_rst_s_valid", 32'(s_valid), 32'd1);
        cyc = -1;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            if (m_ready) begin
                cyc = k;
                break;
            end
            @(posedge clk); #1;
        end
        chk("post_rst_timeout_cycle", 32'(cyc), 32'd8);
        @(posedge clk); #1;
        m_valid = 1'b0;
        @(posedge clk); #1;

        // Watchdog disabled: a hung slave must stall forever with valid passed through.
        z_m_valid = 1'b1; z_m_addr = 32'h5000_0000; z_s_ready = 1'b0; z_s_rdata = 32'h0BAD_F00D;
        bad_cnt = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (z_m_ready !== 1'b0 || z_s_valid !== 1'b1) bad_cnt++;
            @(posedge clk); #1;
        end
        chk("off_hung_bad_cycles", 32'(bad_cnt), 32'd0);
        chk("off_err_flag", 32'(z_err_flag), 32'd0);
        chk("off_err_count", 32'(z_err_count), 32'd0);
        z_s_ready = 1'b1;
        @(negedge clk);
        chk("off_m_ready", 32'(z_m_ready), 32'd1);
        chk("off_m_rdata", z_m_rdata, 32'h0BAD_F00D);
        @(posedge clk); #1;
        z_m_valid = 1'b0; z_s_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
